mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mult_div_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// rtl/mult_div_ctrl.sv - iterative HI/LO multiply/divide unit with E-stage interlock
// Optional divider datapath: define MULT_DIV_CTRL_DIV_EN to include DIV/DIVU.
module mult_div_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_md_valid,
  input  logic [5:0]  E_func,
  input  logic [31:0] E_valA,
  input  logic [31:0] E_valB,
  input  logic        e_flush,
  output logic        e_stall,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] e_md_rdata
);

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  // Shared working pair: product {acc_hi,acc_lo}, or remainder/quotient for divide
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] opb;
  logic        sgn_ab;

  logic        is_mul;
  logic        is_div;
  logic        is_signed;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        start;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] prod_fix;
  logic [31:0] step_hi;
  logic [31:0] step_lo;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign is_mul    = (E_func == FN_MULT) || (E_func == FN_MULTU);
  assign is_signed = (E_func == FN_MULT) || (E_func == FN_DIV);
`ifdef MULT_DIV_CTRL_DIV_EN
  assign is_div    = (E_func == FN_DIV) || (E_func == FN_DIVU);
`else
  assign is_div    = 1'b0;
`endif

  // Flush beats a coincident start; only IDLE may accept a new operation
  assign start  = (state == IDLE) && e_md_valid && (is_mul || is_div) && !e_flush;
  assign sign_a = is_signed & E_valA[31];
  assign sign_b = is_signed & E_valB[31];
  assign abs_a  = sign_a ? -E_valA : E_valA;
  assign abs_b  = sign_b ? -E_valB : E_valB;

  // Shift-add: conditionally add multiplicand to the top half, then shift the 65-bit value right
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
  assign mul_next = {mul_sum, acc_lo[31:1]};
  assign prod_fix = sgn_ab ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

`ifdef MULT_DIV_CTRL_DIV_EN
  logic        op_div;
  logic        sgn_a_q;
  logic        div_zero;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;

  // Restoring step: shift next dividend bit into the remainder and trial-subtract
  assign rem_sh   = {acc_hi, acc_lo[31]};
  assign rem_diff = rem_sh - {1'b0, opb};
`endif

  // Select the per-iteration update and the sign-corrected result for the active op
  always_comb begin
    step_hi = mul_next[63:32];
    step_lo = mul_next[31:0];
    res_hi  = prod_fix[63:32];
    res_lo  = prod_fix[31:0];
`ifdef MULT_DIV_CTRL_DIV_EN
    if (op_div) begin
      step_hi = rem_diff[32] ? rem_sh[31:0] : rem_diff[31:0];
      step_lo = {acc_lo[30:0], ~rem_diff[32]};
      res_hi  = sgn_a_q ? -acc_hi : acc_hi;
      // Zero divisor yields all-ones quotient regardless of sign; remainder restores A
      res_lo  = div_zero ? 32'hFFFF_FFFF : (sgn_ab ? -acc_lo : acc_lo);
    end
`endif
  end

  // Stall only a dependent MD instruction while an operation is in flight
  assign e_stall    = md_busy & e_md_valid;
  assign e_md_rdata = (E_func == FN_MFHI) ? hi :
                      (E_func == FN_MFLO) ? lo : 32'd0;

  // Control FSM, iteration datapath and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      opb      <= 32'd0;
      sgn_ab   <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      md_busy  <= 1'b0;
      md_done  <= 1'b0;
`ifdef MULT_DIV_CTRL_DIV_EN
      op_div   <= 1'b0;
      sgn_a_q  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      md_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CALC;
            md_busy <= 1'b1;
            cnt     <= 5'd0;
            acc_hi  <= 32'd0;
            acc_lo  <= abs_a;
            opb     <= abs_b;
            sgn_ab  <= sign_a ^ sign_b;
`ifdef MULT_DIV_CTRL_DIV_EN
            op_div   <= is_div;
            sgn_a_q  <= sign_a;
            div_zero <= (E_valB == 32'd0);
`endif
          end
        end
        CALC: begin
          if (e_flush) begin
            state   <= IDLE;
            md_busy <= 1'b0;
            cnt     <= 5'd0;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          state   <= IDLE;
          md_busy <= 1'b0;
          if (!e_flush) begin
            hi      <= res_hi;
            lo      <= res_lo;
            md_done <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          md_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb/tb_mult_div_ctrl.sv - randomized self-checking bench for mult_div_ctrl
module tb_mult_div_ctrl;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  // Start edge is edge 1; the edge leaving FIX is edge 34, i.e. 33 edges later
  localparam int LAT = 33;

`ifdef MULT_DIV_CTRL_DIV_EN
  localparam int NF = 4;
  logic [5:0] f_list [NF] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
`else
  localparam int NF = 2;
  logic [5:0] f_list [NF] = '{F_MULT, F_MULTU};
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_md_valid = 1'b0;
  logic [5:0]  E_func = 6'd0;
  logic [31:0] E_valA = 32'd0;
  logic [31:0] E_valB = 32'd0;
  logic        e_flush = 1'b0;
  logic        e_stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] e_md_rdata;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_ctrl dut (
    .clk(clk), .rst_n(rst_n), .e_md_valid(e_md_valid), .E_func(E_func),
    .E_valA(E_valA), .E_valB(E_valB), .e_flush(e_flush), .e_stall(e_stall),
    .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo), .e_md_rdata(e_md_rdata)
  );

  always #5 clk = ~clk;

  // Architectural result from plain 64-bit arithmetic: {hi, lo}
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (f)
      F_MULT:  res = sa * sb;
      F_MULTU: res = {32'd0, a} * {32'd0, b};
      F_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      F_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom();
    endcase
  endfunction

  // Present one op for a single cycle; lat = edges after the start edge until md_done, -1 on timeout
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int lat);
    @(posedge clk); #1;
    e_md_valid = 1'b1; E_func = f; E_valA = a; E_valB = b;
    @(posedge clk); #1;
    e_md_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (md_done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    e_md_valid = 1'b1; E_func = F_MFHI;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
    total++; if (md_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", md_done); end
    total++; if (e_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", e_stall); end
    e_md_valid = 1'b0;
    rst_n = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
  endtask

  task automatic test_mult_directed();
    int lat;
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd5, lat);
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF1;
    total++; if (lat !== LAT) begin bad++; $display("FAIL mult_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (hi !== exp_hi) begin bad++; $display("FAIL mult_hi got=%h exp=%h", hi, exp_hi); end
    total++; if (lo !== exp_lo) begin bad++; $display("FAIL mult_lo got=%h exp=%h", lo, exp_lo); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL mult_busy_after got=%b exp=0", md_busy); end
    @(posedge clk); #1;
    total++; if (md_done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", md_done); end
  endtask

  task automatic test_div();
    int lat;
`ifdef MULT_DIV_CTRL_DIV_EN
    run_op(F_DIVU, 32'd100, 32'd7, lat);
    total++; if ({hi, lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_result got=%h_%h exp=%h_%h", hi, lo, 32'd2, 32'd14); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL divu_latency got=%0d exp=%0d", lat, LAT); end
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    total++; if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin bad++; $display("FAIL div_signed got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
    run_op(F_DIVU, 32'h1234, 32'd0, lat);
    total++; if ({hi, lo} !== {32'h1234, 32'hFFFF_FFFF}) begin bad++; $display("FAIL div_zero got=%h_%h exp=00001234_ffffffff", hi, lo); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL div_zero_latency got=%0d exp=%0d", lat, LAT); end
    exp_hi = 32'h1234; exp_lo = 32'hFFFF_FFFF;
`else
    lat = 0;
    @(posedge clk); #1;
    e_md_valid = 1'b1; E_func = F_DIVU; E_valA = 32'd100; E_valB = 32'd7;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (md_busy !== 1'b0) lat++;
      if (e_stall !== 1'b0) lat++;
    end
    e_md_valid = 1'b0;
    total++; if (lat !== 0) begin bad++; $display("FAIL nodiv_busy_stall got=%0d exp=0", lat); end
    total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL nodiv_hilo got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo); end
`endif
  endtask

  task automatic test_random();
    int lat;
    logic [5:0] f;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      f = f_list[$urandom_range(0, NF - 1)];
      a = pick_op();
      b = pick_op();
      run_op(f, a, b, lat);
      {exp_hi, exp_lo} = ref_md(f, a, b);
      total++; if (lat !== LAT) begin bad++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, LAT); end
      total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL rand_result[%0d] f=%h a=%h b=%h got=%h_%h exp=%h_%h", i, f, a, b, hi, lo, exp_hi, exp_lo); end
    end
  endtask

  task automatic test_mf();
    @(posedge clk); #1;
    e_md_valid = 1'b1; E_func = F_MFHI;
    #1;
    total++; if (e_md_rdata !== exp_hi) begin bad++; $display("FAIL mfhi got=%h exp=%h", e_md_rdata, exp_hi); end
    total++; if (e_stall !== 1'b0) begin bad++; $display("FAIL mf_idle_stall got=%b exp=0", e_stall); end
    E_func = F_MFLO;
    #1;
    total++; if (e_md_rdata !== exp_lo) begin bad++; $display("FAIL mflo got=%h exp=%h", e_md_rdata, exp_lo); end
    e_md_valid = 1'b0; E_func = 6'h00;
    #1;
    total++; if (e_md_rdata !== 32'd0) begin bad++; $display("FAIL rdata_other got=%h exp=0", e_md_rdata); end
  endtask

  task automatic test_stall();
    int n_stall;
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    @(posedge clk); #1;
    e_md_valid = 1'b1; E_func = F_MULT; E_valA = a; E_valB = b;
    @(posedge clk); #1;
    E_func = F_MFHI;
    {exp_hi, exp_lo} = ref_md(F_MULT, a, b);
    n_stall = 0;
    for (int k = 0; k < 60; k++) begin
      if (!e_stall) break;
      n_stall++;
      @(posedge clk); #1;
    end
    total++; if (n_stall !== LAT) begin bad++; $display("FAIL stall_cycles got=%0d exp=%0d", n_stall, LAT); end
    total++; if (e_md_rdata !== exp_hi) begin bad++; $display("FAIL stall_mfhi got=%h exp=%h", e_md_rdata, exp_hi); end
    e_md_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] r1, r2;
    a1 = $urandom(); b1 = $urandom(); a2 = $urandom(); b2 = $urandom();
    r1 = ref_md(F_MULT, a1, b1);
    r2 = ref_md(F_MULTU, a2, b2);
    @(posedge clk); #1;
    e_md_valid = 1'b1; E_func = F_MULT; E_valA = a1; E_valB = b1;
    @(posedge clk); #1;
    E_func = F_MULTU; E_valA = a2; E_valB = b2;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (md_done) begin lat = k; break; end
    end
    total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, LAT); end
    total++; if ({hi, lo} !== r1) begin bad++; $display("FAIL b2b_first got=%h_%h exp=%h", hi, lo, r1); end
    total++; if (e_stall !== 1'b0) begin bad++; $display("FAIL b2b_idle_stall got=%b exp=0", e_stall); end
    @(posedge clk); #1;
    e_md_valid = 1'b0;
    total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL b2b_held_start got=%b exp=1", md_busy); end
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (md_done) begin lat = k; break; end
    end
    total++; if (lat !== LAT) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, LAT); end
    total++; if ({hi, lo} !== r2) begin bad++; $display("FAIL b2b_second got=%h_%h exp=%h", hi, lo, r2); end
    exp_hi = r2[63:32]; exp_lo = r2[31:0];
  endtask

  task automatic test_flush();
    int dones;
    @(posedge clk); #1;
    e_md_valid = 1'b1; E_func = F_MULTU; E_valA = $urandom() | 32'h1; E_valB = $urandom() | 32'h1;
    @(posedge clk); #1;
    e_md_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    e_flush = 1'b1;
    @(posedge clk); #1;
    e_flush = 1'b0;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", md_busy); end
    dones = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (md_done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL flush_done got=%0d exp=0", dones); end
    total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL flush_hilo got=%h_%h exp=%h_%h", hi, lo, exp_hi, exp_lo); end
    @(posedge clk); #1;
    e_md_valid = 1'b1; e_flush = 1'b1; E_func = F_MULT; E_valA = 32'd3; E_valB = 32'd3;
    @(posedge clk); #1;
    e_md_valid = 1'b0; e_flush = 1'b0;
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%b exp=0", md_busy); end
    dones = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (md_done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL flush_start_done got=%0d exp=0", dones); end
  endtask

  task automatic test_reset_midop();
    int dones;
    @(posedge clk); #1;
    e_md_valid = 1'b1; E_func = F_MULT; E_valA = 32'h7; E_valB = 32'h9;
    @(posedge clk); #1;
    e_md_valid = 1'b1; E_func = F_MFLO;
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if ({hi, lo} !== 64'd0) begin bad++; $display("FAIL midreset_hilo got=%h_%h exp=0", hi, lo); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", md_busy); end
    total++; if (e_stall !== 1'b0) begin bad++; $display("FAIL midreset_stall got=%b exp=0", e_stall); end
    e_md_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_hi = 32'd0; exp_lo = 32'd0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (md_done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL midreset_done got=%0d exp=0", dones); end
    total++; if ({hi, lo} !== {exp_hi, exp_lo}) begin bad++; $display("FAIL midreset_after got=%h_%h exp=0", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div();
    test_random();
    test_mf();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
